// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller feeding the CPU control unit.
// Synchronises IRQ lines, latches rising edges as pending, applies a mask,
// picks the lowest-index enabled request and tracks one in-service interrupt.
// Optional build macro: INT_CTRL_LEVEL_EN (level-sensitive lines, no pending
// latch, no edge detectors).
module int_ctrl #(
  parameter int                NIRQ            = 4,
  parameter int                VEC_W           = 10,
  parameter logic [VEC_W-1:0]  VEC_BASE        = 10'h3C0,
  parameter int                VEC_STRIDE_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NIRQ-1:0]   irq,
  input  logic              mask_we,
  input  logic [NIRQ-1:0]   mask_d,
  output logic [NIRQ-1:0]   mask_q,
  output logic              int_req,
  output logic [VEC_W-1:0]  int_vec,
  input  logic              int_ack,
  input  logic              int_ret,
  output logic [NIRQ-1:0]   pending,
  output logic [NIRQ-1:0]   in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state;
  logic [NIRQ-1:0]   sync1;
  logic [NIRQ-1:0]   sync2;
  logic [NIRQ-1:0]   mask_r;
  logic [NIRQ-1:0]   sel;
  logic [NIRQ-1:0]   in_svc;
  logic [NIRQ-1:0]   pend_view;
  logic [NIRQ-1:0]   cand;
  logic [NIRQ-1:0]   lowest;
  logic [VEC_W-1:0]  idx_ext;
  logic [VEC_W-1:0]  vec_next;
  logic [VEC_W-1:0]  vec_r;
  logic              req_r;

  // Two-flop synchroniser on every IRQ line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
    end
  end

`ifdef INT_CTRL_LEVEL_EN
  // Level mode: the synchronised line itself is the request.
  assign pend_view = sync2;
`else
  logic [NIRQ-1:0] prev;
  logic [NIRQ-1:0] pend_r;
  logic [NIRQ-1:0] edge_det;
  logic [NIRQ-1:0] clr;

  assign edge_det = sync2 & ~prev;
  assign clr      = (state == REQ && int_ack) ? sel : '0;

  // Edge latch: a new edge in the ack cycle wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev   <= '0;
      pend_r <= '0;
    end else begin
      prev   <= sync2;
      pend_r <= (pend_r & ~clr) | edge_det;
    end
  end

  assign pend_view = pend_r;
`endif

  // Mask register; everything enabled out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= '1;
    end else if (mask_we) begin
      mask_r <= mask_d;
    end
  end

  assign cand   = pend_view & mask_r;
  assign lowest = cand & (~cand + NIRQ'(1));

  // Encode the one-hot winner and form its handler address.
  always_comb begin
    idx_ext = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (lowest[i]) idx_ext = VEC_W'(i);
    end
    vec_next = VEC_BASE + (idx_ext << VEC_STRIDE_LOG2);
  end

  // Control FSM: selection is latched on entry to REQ and frozen until ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      in_svc <= '0;
      vec_r  <= '0;
      req_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            sel   <= lowest;
            vec_r <= vec_next;
            req_r <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            in_svc <= sel;
            vec_r  <= '0;
            req_r  <= 1'b0;
            state  <= SERVICE;
          end
        end
        SERVICE: begin
          if (int_ret) begin
            in_svc <= '0;
            sel    <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          req_r <= 1'b0;
        end
      endcase
    end
  end

  assign mask_q     = mask_r;
  assign int_req    = req_r;
  assign int_vec    = vec_r;
  assign pending    = pend_view;
  assign in_service = in_svc;

endmodule
